alu_resp_tx: RTL and testbench



---
 rtl/alu_resp_tx.sv | 195 +++++++++++++++++++
 tb/tb_alu_resp_tx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_resp_tx.sv
// alu_resp_tx: frames one ALU result per handshake into an AXI-Stream byte packet for uart_tx.
// Optional feature macro ALU_RESP_CHECKSUM_EN appends an XOR checksum byte after the data.
module alu_resp_tx #(
    parameter int         DataWidth = 32,
    parameter logic [7:0] PadByte   = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 result_valid_i,
    output logic                 result_ready_o,
    input  logic [7:0]           result_opcode_i,
    input  logic [DataWidth-1:0] result_data_i,
    output logic [7:0]           m_axis_tdata_o,
    output logic                 m_axis_tvalid_o,
    input  logic                 m_axis_tready_i,
    output logic                 busy_o
);

    localparam int NumDataBytes = DataWidth / 8;
`ifdef ALU_RESP_CHECKSUM_EN
    localparam int PktLen = 4 + NumDataBytes + 1;
`else
    localparam int PktLen = 4 + NumDataBytes;
`endif
    localparam int              CntW     = $clog2(PktLen);
    localparam logic [15:0]     LenField = 16'(PktLen);
    localparam logic [CntW-1:0] HdrLast  = CntW'(3);
    localparam logic [CntW-1:0] DataLast = CntW'(NumDataBytes - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
`ifdef ALU_RESP_CHECKSUM_EN
        DATA,
        CSUM
`else
        DATA
`endif
    } state_t;

    state_t                r_state;
    logic [CntW-1:0]       r_cnt;
    logic [7:0]            r_opcode;
    logic [DataWidth-1:0]  r_data;
    logic                  r_ready;
    logic                  r_tvalid;
    logic [7:0]            r_tdata;
    logic                  r_busy;
`ifdef ALU_RESP_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    logic                  w_xfer;
    logic [CntW-1:0]       w_cntNext;
    logic [CntW-1:0]       w_dataIdx;
    logic [7:0]            w_hdrNext;
    logic [7:0]            w_dataNext;

    assign w_xfer    = r_tvalid & m_axis_tready_i;
    assign w_cntNext = r_cnt + 1'b1;

    // Header byte that follows the one currently on the bus.
    always_comb begin
        w_hdrNext = r_opcode;
        case (w_cntNext[1:0])
            2'd1:    w_hdrNext = PadByte;
            2'd2:    w_hdrNext = LenField[7:0];
            2'd3:    w_hdrNext = LenField[15:8];
            default: w_hdrNext = r_opcode;
        endcase
    end

    // Leaving HDR presents data byte 0; inside DATA the next byte is cnt+1.
    always_comb begin
        w_dataIdx  = (r_state == DATA) ? w_cntNext : '0;
        w_dataNext = r_data[7:0];
        for (int k = 0; k < NumDataBytes; k++) begin
            if (w_dataIdx == CntW'(k)) begin
                w_dataNext = r_data[k*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_opcode <= 8'h00;
            r_data   <= '0;
            r_ready  <= 1'b1;
            r_tvalid <= 1'b0;
            r_tdata  <= 8'h00;
            r_busy   <= 1'b0;
`ifdef ALU_RESP_CHECKSUM_EN
            r_csum   <= 8'h00;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (result_valid_i && r_ready) begin
                        r_opcode <= result_opcode_i;
                        r_data   <= result_data_i;
                        r_state  <= HDR;
                        r_cnt    <= '0;
                        r_ready  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_tvalid <= 1'b1;
                        r_tdata  <= result_opcode_i;
`ifdef ALU_RESP_CHECKSUM_EN
                        r_csum   <= 8'h00;
`endif
                    end
                end

                HDR: begin
                    if (w_xfer) begin
`ifdef ALU_RESP_CHECKSUM_EN
                        r_csum <= r_csum ^ r_tdata;
`endif
                        if (r_cnt == HdrLast) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                            r_tdata <= w_dataNext;
                        end else begin
                            r_cnt   <= w_cntNext;
                            r_tdata <= w_hdrNext;
                        end
                    end
                end

                DATA: begin
                    if (w_xfer) begin
                        if (r_cnt == DataLast) begin
`ifdef ALU_RESP_CHECKSUM_EN
                            // The checksum byte folds in the data byte leaving right now.
                            r_csum  <= r_csum ^ r_tdata;
                            r_state <= CSUM;
                            r_cnt   <= '0;
                            r_tdata <= r_csum ^ r_tdata;
`else
                            r_state  <= IDLE;
                            r_cnt    <= '0;
                            r_tvalid <= 1'b0;
                            r_tdata  <= 8'h00;
                            r_ready  <= 1'b1;
                            r_busy   <= 1'b0;
`endif
                        end else begin
`ifdef ALU_RESP_CHECKSUM_EN
                            r_csum  <= r_csum ^ r_tdata;
`endif
                            r_cnt   <= w_cntNext;
                            r_tdata <= w_dataNext;
                        end
                    end
                end

`ifdef ALU_RESP_CHECKSUM_EN
                CSUM: begin
                    if (w_xfer) begin
                        r_state  <= IDLE;
                        r_cnt    <= '0;
                        r_tvalid <= 1'b0;
                        r_tdata  <= 8'h00;
                        r_ready  <= 1'b1;
                        r_busy   <= 1'b0;
                    end
                end
`endif

                default: begin
                    r_state  <= IDLE;
                    r_cnt    <= '0;
                    r_tvalid <= 1'b0;
                    r_tdata  <= 8'h00;
                    r_ready  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign result_ready_o  = r_ready;
    assign m_axis_tvalid_o = r_tvalid;
    assign m_axis_tdata_o  = r_tdata;
    assign busy_o          = r_busy;

    // A stalled byte must stay put until the sink takes it.
    a_holdStable: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_tvalid && !m_axis_tready_i) |=> (r_tvalid && $stable(r_tdata)));

    a_readyBusyExclusive: assert property (@(posedge clk_i) disable iff (rst_i)
        (r_ready != r_busy));

endmodule

// File: tb/tb_alu_resp_tx.sv
// Bench for alu_resp_tx: a 32-bit and an 8-bit instance checked every cycle against a packet-queue model.
`timescale 1ns/1ps
module tb_alu_resp_tx;

    localparam int NbA = 4;
    localparam int NbB = 1;
`ifdef ALU_RESP_CHECKSUM_EN
    localparam int CsBytes = 1;
`else
    localparam int CsBytes = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        validA, readyA, treadyA, tvalidA, busyA;
    logic [7:0]  opA, tdataA;
    logic [31:0] dataA;
    logic        validB, readyB, treadyB, tvalidB, busyB;
    logic [7:0]  opB, tdataB;
    logic [7:0]  dataB;

    int total = 0;
    int bad   = 0;

    logic [7:0] expQA[$];
    logic [7:0] expQB[$];
    logic [7:0] logA[$];
    logic [7:0] logB[$];
    logic [7:0] wantQ[$];
    bit         idleA, idleB;

    alu_resp_tx #(.DataWidth(32), .PadByte(8'h00)) dutA (
        .clk_i(clk), .rst_i(rst),
        .result_valid_i(validA), .result_ready_o(readyA),
        .result_opcode_i(opA), .result_data_i(dataA),
        .m_axis_tdata_o(tdataA), .m_axis_tvalid_o(tvalidA),
        .m_axis_tready_i(treadyA), .busy_o(busyA)
    );

    alu_resp_tx #(.DataWidth(8), .PadByte(8'h00)) dutB (
        .clk_i(clk), .rst_i(rst),
        .result_valid_i(validB), .result_ready_o(readyB),
        .result_opcode_i(opB), .result_data_i(dataB),
        .m_axis_tdata_o(tdataB), .m_axis_tvalid_o(tvalidB),
        .m_axis_tready_i(treadyB), .busy_o(busyB)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a whole packet is queued at capture; bytes leave the queue on each transfer.
    task automatic pushPacket(input int which, input logic [7:0] op, input logic [63:0] d, input int nb);
        logic [7:0] pkt[$];
        logic [7:0] x;
        int         len;
        len = 4 + nb + CsBytes;
        pkt.push_back(op);
        pkt.push_back(8'h00);
        pkt.push_back(len[7:0]);
        pkt.push_back(len[15:8]);
        for (int i = 0; i < nb; i++) pkt.push_back(d[8*i +: 8]);
        if (CsBytes == 1) begin
            x = 8'h00;
            foreach (pkt[i]) x = x ^ pkt[i];
            pkt.push_back(x);
        end
        foreach (pkt[i]) begin
            if (which == 0) expQA.push_back(pkt[i]);
            else            expQB.push_back(pkt[i]);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            expQA.delete();
        end else begin
            idleA = (expQA.size() == 0);
            checkOutput("A.ready",  64'(readyA),  64'(idleA));
            checkOutput("A.busy",   64'(busyA),   64'(!idleA));
            checkOutput("A.tvalid", 64'(tvalidA), 64'(!idleA));
            if (!idleA) begin
                checkOutput("A.tdata", 64'(tdataA), 64'(expQA[0]));
                if (treadyA) begin
                    logA.push_back(tdataA);
                    void'(expQA.pop_front());
                end
            end else if (validA) begin
                pushPacket(0, opA, 64'(dataA), NbA);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            expQB.delete();
        end else begin
            idleB = (expQB.size() == 0);
            checkOutput("B.ready",  64'(readyB),  64'(idleB));
            checkOutput("B.busy",   64'(busyB),   64'(!idleB));
            checkOutput("B.tvalid", 64'(tvalidB), 64'(!idleB));
            if (!idleB) begin
                checkOutput("B.tdata", 64'(tdataB), 64'(expQB[0]));
                if (treadyB) begin
                    logB.push_back(tdataB);
                    void'(expQB.pop_front());
                end
            end else if (validB) begin
                pushPacket(1, opB, 64'(dataB), NbB);
            end
        end
    end

    task automatic waitReady(input int which);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if ((which == 0) ? readyA : readyB) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL waitReady: ready never rose within 100 cycles (dut %0d)", which);
    endtask

    task automatic waitLog(input int which, input int n);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (((which == 0) ? logA.size() : logB.size()) >= n) return;
        end
        total++;
        bad++;
        $display("[TB] FAIL waitLog: got %0d bytes need %0d (dut %0d)",
                 (which == 0) ? logA.size() : logB.size(), n, which);
    endtask

    task automatic applyStimulus(input int which, input logic [7:0] op, input logic [31:0] d);
        @(posedge clk);
        #1;
        if (which == 0) begin
            validA = 1'b1; opA = op; dataA = d;
        end else begin
            validB = 1'b1; opB = op; dataB = d[7:0];
        end
        waitReady(which);
        @(posedge clk);
        #1;
        if (which == 0) validA = 1'b0;
        else            validB = 1'b0;
    endtask

    task automatic checkLog(input string name, input int which, input int start);
        logic [63:0] act;
        for (int i = 0; i < wantQ.size(); i++) begin
            act = 64'h1FF;
            if (which == 0 && start + i < logA.size()) act = 64'(logA[start+i]);
            if (which == 1 && start + i < logB.size()) act = 64'(logB[start+i]);
            checkOutput($sformatf("%s.byte%0d", name, i), act, 64'(wantQ[i]));
        end
    endtask

    initial begin
        rst = 1'b1;
        validA = 1'b0; opA = 8'h00; dataA = 32'h0; treadyA = 1'b1;
        validB = 1'b0; opB = 8'h00; dataB = 8'h0;  treadyB = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset.readyA",  64'(readyA),  64'd1);
        checkOutput("reset.tvalidA", 64'(tvalidA), 64'd0);
        checkOutput("reset.tdataA",  64'(tdataA),  64'h00);
        checkOutput("reset.busyA",   64'(busyA),   64'd0);
        checkOutput("reset.readyB",  64'(readyB),  64'd1);

        // Basic packet with tready held high
        logA.delete();
        applyStimulus(0, 8'h03, 32'h12345678);
        waitLog(0, 8 + CsBytes);
`ifdef ALU_RESP_CHECKSUM_EN
        wantQ = '{8'h03, 8'h00, 8'h09, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h02};
`else
        wantQ = '{8'h03, 8'h00, 8'h08, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`endif
        checkLog("basic", 0, 0);
        @(negedge clk);
        checkOutput("basic.readyAfter", 64'(readyA), 64'd1);

        // Backpressure while the first data byte is presented
        logA.delete();
        applyStimulus(0, 8'h03, 32'h12345678);
        waitLog(0, 4);
        @(posedge clk);
        #1 treadyA = 1'b0;
        repeat (5) begin
            @(negedge clk);
            checkOutput("stall.tdata",  64'(tdataA),  64'h78);
            checkOutput("stall.tvalid", 64'(tvalidA), 64'd1);
        end
        @(posedge clk);
        #1 treadyA = 1'b1;
        waitLog(0, 8 + CsBytes);
        checkLog("stall", 0, 0);

        // Second result held valid while the first packet is in flight
        logA.delete();
        applyStimulus(0, 8'h11, 32'hCAFEF00D);
        validA = 1'b1; opA = 8'h01; dataA = 32'hDEADBEEF;
        waitReady(0);
        @(posedge clk);
        #1 validA = 1'b0;
        waitLog(0, 2 * (8 + CsBytes));
`ifdef ALU_RESP_CHECKSUM_EN
        wantQ = '{8'h11, 8'h00, 8'h09, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'hD1};
`else
        wantQ = '{8'h11, 8'h00, 8'h08, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
`endif
        checkLog("b2bFirst", 0, 0);
`ifdef ALU_RESP_CHECKSUM_EN
        wantQ = '{8'h01, 8'h00, 8'h09, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h2A};
`else
        wantQ = '{8'h01, 8'h00, 8'h08, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`endif
        checkLog("b2bSecond", 0, 8 + CsBytes);

        // Reset after three bytes, then a fresh packet
        logA.delete();
        applyStimulus(0, 8'h22, 32'h44332211);
        waitLog(0, 3);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("abort.tvalid", 64'(tvalidA), 64'd0);
        checkOutput("abort.ready",  64'(readyA),  64'd1);
        checkOutput("abort.busy",   64'(busyA),   64'd0);
        logA.delete();
        applyStimulus(0, 8'h05, 32'h00000001);
        waitLog(0, 8 + CsBytes);
`ifdef ALU_RESP_CHECKSUM_EN
        wantQ = '{8'h05, 8'h00, 8'h09, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h0D};
`else
        wantQ = '{8'h05, 8'h00, 8'h08, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
`endif
        checkLog("afterAbort", 0, 0);

        // 8-bit instance
        logB.delete();
        applyStimulus(1, 8'hAA, 32'h0000007F);
        waitLog(1, 5 + CsBytes);
`ifdef ALU_RESP_CHECKSUM_EN
        wantQ = '{8'hAA, 8'h00, 8'h06, 8'h00, 8'h7F, 8'hD3};
`else
        wantQ = '{8'hAA, 8'h00, 8'h05, 8'h00, 8'h7F};
`endif
        checkLog("narrow", 1, 0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
